// File: rtl/qam16_tx_symbol_source.sv
// rtl/qam16_tx_symbol_source.sv - 16-QAM symbol source: LFSR/counting symbols, Gray I/Q mapping, 4x zero-stuffing
// Also exports a strobe-delayed symbol reference and a frame boundary pulse.
module qam16_tx_symbol_source #(
  parameter logic signed [17:0] AMP_A     = 18'sd32768,
  parameter int                 FRAME_LEN = 1048576,
  parameter int                 REF_DELAY = 2
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                sam_clk_ena,
  input  logic                sym_clk_ena,
  input  logic                pattern_sel,
  input  logic                seed_load,
  input  logic [21:0]         seed,
  output logic signed [17:0]  i_out,
  output logic signed [17:0]  q_out,
  output logic [3:0]          sym_ref,
  output logic                frame_start
);

  localparam int                FW         = $clog2(FRAME_LEN);
  localparam logic [FW-1:0]     FRAME_LAST = FW'(FRAME_LEN - 1);
  localparam logic signed [17:0] LVL_A     = AMP_A;
  localparam logic signed [17:0] LVL_3A    = 18'(AMP_A * 3);

  logic [21:0]        r_lfsr;
  logic [3:0]         r_cnt;
  logic [1:0]         r_phase;
  logic [FW-1:0]      r_frame_cnt;
  logic               r_frame_start;
  logic signed [17:0] r_i;
  logic signed [17:0] r_q;
  logic [3:0]         r_ref [REF_DELAY];

  logic               w_strobe;
  logic [3:0]         w_sym;
  logic [21:0]        w_lfsr_next;
  logic signed [17:0] w_i_lvl;
  logic signed [17:0] w_q_lvl;

  // Gray-coded amplitude: adjacent levels differ in one bit.
  function automatic logic signed [17:0] f_map(input logic [1:0] g);
    case (g)
      2'b00:   f_map = -LVL_3A;
      2'b01:   f_map = -LVL_A;
      2'b11:   f_map = LVL_A;
      default: f_map = LVL_3A;
    endcase
  endfunction

  assign w_strobe = sym_clk_ena & sam_clk_ena;
  assign w_sym    = pattern_sel ? r_cnt : r_lfsr[3:0];
  assign w_i_lvl  = f_map(w_sym[1:0]);
  assign w_q_lvl  = f_map(w_sym[3:2]);

  // An all-zero seed would lock the LFSR, so it is replaced by all ones.
  always_comb begin
    w_lfsr_next = {r_lfsr[20:0], r_lfsr[21] ^ r_lfsr[20]};
    if (seed_load) begin
      w_lfsr_next = (seed == 22'd0) ? 22'h3FFFFF : seed;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr        <= 22'h3FFFFF;
      r_cnt         <= 4'd0;
      r_phase       <= 2'd0;
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b0;
      r_i           <= '0;
      r_q           <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_strobe) begin
        r_lfsr      <= w_lfsr_next;
        r_cnt       <= r_cnt + 4'd1;
        r_phase     <= 2'd0;
        r_i         <= w_i_lvl;
        r_q         <= w_q_lvl;
        if (r_frame_cnt == FRAME_LAST) begin
          r_frame_cnt   <= '0;
          r_frame_start <= 1'b1;
        end else begin
          r_frame_cnt   <= r_frame_cnt + 1'b1;
        end
      end else if (sam_clk_ena) begin
        r_phase     <= r_phase + 2'd1;
        r_i         <= '0;
        r_q         <= '0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < REF_DELAY; k++) r_ref[k] <= 4'd0;
    end else if (w_strobe) begin
      r_ref[0] <= w_sym;
      for (int k = 1; k < REF_DELAY; k++) r_ref[k] <= r_ref[k-1];
    end
  end

  assign i_out       = r_i;
  assign q_out       = r_q;
  assign sym_ref     = r_ref[REF_DELAY-1];
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_qam16_tx_symbol_source.sv
// tb/tb_qam16_tx_symbol_source.sv - self-checking bench for qam16_tx_symbol_source
module tb_qam16_tx_symbol_source;

  localparam int FRAME_LEN = 8;
  localparam int REF_DELAY = 2;
  localparam int A         = 32768;

  logic               sys_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               sam_clk_ena = 1'b0;
  logic               sym_clk_ena = 1'b0;
  logic               pattern_sel = 1'b0;
  logic               seed_load = 1'b0;
  logic [21:0]        seed = 22'd0;
  logic signed [17:0] i_out;
  logic signed [17:0] q_out;
  logic [3:0]         sym_ref;
  logic               frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  qam16_tx_symbol_source #(
    .AMP_A(18'sd32768), .FRAME_LEN(FRAME_LEN), .REF_DELAY(REF_DELAY)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .sam_clk_ena(sam_clk_ena),
    .sym_clk_ena(sym_clk_ena), .pattern_sel(pattern_sel), .seed_load(seed_load),
    .seed(seed), .i_out(i_out), .q_out(q_out), .sym_ref(sym_ref),
    .frame_start(frame_start)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state
  int          m_lfsr, m_cnt, m_fcnt, m_i, m_q;
  logic        m_fs;
  int          m_ref_q[$];

  int          snap_i, snap_q, snap_ref, snap_fs, fs_hits;

  function automatic int level(input int g);
    int idx;
    // Gray code to amplitude index 0..3, then odd-integer multiple of a
    idx = (g == 0) ? 0 : (g == 1) ? 1 : (g == 3) ? 2 : 3;
    return (2 * idx - 3) * A;
  endfunction

  task automatic model_reset();
    m_lfsr = 'h3FFFFF; m_cnt = 0; m_fcnt = 0; m_i = 0; m_q = 0; m_fs = 1'b0;
    m_ref_q = {};
    for (int k = 0; k < REF_DELAY; k++) m_ref_q.push_back(0);
  endtask

  task automatic model_step(input logic sam, input logic sym);
    int s;
    m_fs = 1'b0;
    if (sam && sym) begin
      s = pattern_sel ? m_cnt : (m_lfsr % 16);
      m_i = level(s % 4);
      m_q = level(s / 4);
      m_ref_q.push_back(s);
      void'(m_ref_q.pop_front());
      m_fs   = (m_fcnt == FRAME_LEN - 1);
      m_fcnt = (m_fcnt + 1) % FRAME_LEN;
      m_cnt  = (m_cnt + 1) % 16;
      if (seed_load) m_lfsr = (seed == 0) ? 'h3FFFFF : int'(seed);
      else m_lfsr = ((m_lfsr * 2) % (1 << 22)) + (((m_lfsr >> 21) + (m_lfsr >> 20)) % 2);
    end else if (sam) begin
      m_i = 0;
      m_q = 0;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic do_cycle(input logic sam, input logic sym);
    sam_clk_ena = sam;
    sym_clk_ena = sym;
    model_step(sam, sym);
    @(posedge sys_clk);
    #1;
    n_tests++;
    if (int'(i_out) != m_i || int'(q_out) != m_q || int'(sym_ref) != m_ref_q[0] || frame_start != m_fs) begin
      n_fail++;
      $display("FAIL model: got i=%0d q=%0d ref=%0h fs=%0b expected i=%0d q=%0d ref=%0h fs=%0b (t=%0t)",
               i_out, q_out, sym_ref, frame_start, m_i, m_q, m_ref_q[0], m_fs, $time);
    end
    if (frame_start) fs_hits++;
    @(negedge sys_clk);
  endtask

  // One symbol period: strobe, then three zero-stuffed sample enables, 4 cycles apart.
  task automatic run_symbol(input logic psel, input logic sload, input logic [21:0] sd, input logic stray);
    pattern_sel = psel;
    seed_load   = sload;
    seed        = sd;
    do_cycle(1'b1, 1'b1);
    snap_i = int'(i_out); snap_q = int'(q_out); snap_ref = int'(sym_ref); snap_fs = int'(frame_start);
    seed_load = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (p != 0) do_cycle(1'b1, 1'b0);
      for (int c = 0; c < 3; c++) do_cycle(1'b0, stray && ($urandom_range(0, 4) == 0));
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    sam_clk_ena = 1'b0;
    sym_clk_ena = 1'b0;
    #1;
    check("async_reset_i", int'(i_out), 0);
    check("async_reset_q", int'(q_out), 0);
    check("async_reset_ref", int'(sym_ref), 0);
    check("async_reset_fs", int'(frame_start), 0);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset_n = 1'b1;
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b0);
  endtask

  typedef struct {
    logic        psel;
    logic        sload;
    logic [21:0] sd;
    int          ei;
    int          eq;
    int          eref;
    int          efs;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 22'd0,  32768,  32768, 'h0, 0};
    tbl[1] = '{1'b0, 1'b0, 22'd0,  98304,  32768, 'hF, 0};
    tbl[2] = '{1'b0, 1'b0, 22'd0, -98304,  32768, 'hE, 0};
    tbl[3] = '{1'b0, 1'b1, 22'd5, -98304,  98304, 'hC, 0};
    tbl[4] = '{1'b0, 1'b0, 22'd0, -32768, -32768, 'h8, 0};
    tbl[5] = '{1'b0, 1'b1, 22'd0,  98304,  98304, 'h5, 0};
    tbl[6] = '{1'b0, 1'b0, 22'd0,  32768,  32768, 'hA, 0};
    tbl[7] = '{1'b0, 1'b0, 22'd0,  98304,  32768, 'hF, 1};
    tbl[8] = '{1'b0, 1'b0, 22'd0, -98304,  32768, 'hE, 0};

    model_reset();
    @(negedge sys_clk);
    check("reset_i", int'(i_out), 0);
    check("reset_q", int'(q_out), 0);
    check("reset_fs", int'(frame_start), 0);
    apply_reset();

    // Directed vectors: LFSR start-up, seed load, zero seed
    for (int v = 0; v < 9; v++) begin
      run_symbol(tbl[v].psel, tbl[v].sload, tbl[v].sd, 1'b0);
      check($sformatf("tbl%0d_i", v), snap_i, tbl[v].ei);
      check($sformatf("tbl%0d_q", v), snap_q, tbl[v].eq);
      check($sformatf("tbl%0d_ref", v), snap_ref, tbl[v].eref);
      check($sformatf("tbl%0d_fs", v), snap_fs, tbl[v].efs);
    end

    // sym_clk_ena alone must not advance anything; next symbol is still the LFSR successor
    for (int c = 0; c < 3; c++) do_cycle(1'b0, 1'b1);
    check("stray_sym_hold_i", int'(i_out), 0);
    run_symbol(1'b0, 1'b0, 22'd0, 1'b0);
    check("after_stray_ref", snap_ref, 'hC);

    // Counting pattern: sym_ref walks 0..F then 0, and all 16 I/Q pairs appear once
    apply_reset();
    begin
      logic [15:0] seen;
      seen = '0;
      for (int n = 1; n <= 18; n++) begin
        run_symbol(1'b1, 1'b0, 22'd0, 1'b0);
        check($sformatf("count_ref%0d", n), snap_ref, (n >= 2) ? (n - 2) % 16 : 0);
        if (n <= 16) seen[((snap_i / A + 3) / 2) * 4 + (snap_q / A + 3) / 2] = 1'b1;
      end
      check("iq_coverage", $countones(seen), 16);
    end

    // Frame pulse: reset mid-frame at strobe 5 restarts the count
    apply_reset();
    for (int n = 0; n < 5; n++) run_symbol(1'b0, 1'b0, 22'd0, 1'b0);
    apply_reset();
    fs_hits = 0;
    for (int n = 1; n <= 16; n++) begin
      run_symbol(1'b0, 1'b0, 22'd0, 1'b0);
      check($sformatf("frame_fs%0d", n), snap_fs, (n % 8 == 0) ? 1 : 0);
    end
    check("frame_pulse_cycles", fs_hits, 2);

    // Randomized symbols against the model, with stray symbol enables in idle slots
    for (int n = 0; n < 150; n++) begin
      logic [21:0] sd;
      sd = ($urandom_range(0, 3) == 0) ? 22'd0 : 22'($urandom);
      run_symbol(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), sd, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
